// File: rtl/fetch_unit.sv
// Y86-64 SEQ fetch stage: byte-serial instruction read over imem req/ack,
// decoded fields returned downstream on a valid/ready handshake.
module fetch_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] pc,
    input  logic        pc_valid,
    output logic        pc_ready,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [7:0]  imem_rdata,
    input  logic        imem_error,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic        instr_invalid,
    output logic        mem_error
);

    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_e;

    state_e      state_q;
    logic [63:0] pc_q;
    logic [3:0]  cnt_q;
    logic        imem_req_q;
    logic [63:0] imem_addr_q;
    logic        out_valid_q;
    logic [3:0]  icode_q, ifun_q, ra_q, rb_q;
    logic [63:0] valc_q, valp_q;
    logic        invalid_q, mem_error_q;

    logic [3:0]  cur_icode_d;
    logic [3:0]  len_d;
    logic [2:0]  valc_idx_d;
    logic        last_d;

    function automatic logic [3:0] instr_len(input logic [3:0] ic);
        case (ic)
            4'h2, 4'h6, 4'hA, 4'hB: instr_len = 4'd2;
            4'h7, 4'h8:             instr_len = 4'd9;
            4'h3, 4'h4, 4'h5:       instr_len = 4'd10;
            default:                instr_len = 4'd1;
        endcase
    endfunction

    function automatic logic has_regids(input logic [3:0] ic);
        case (ic)
            4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: has_regids = 1'b1;
            default:                                  has_regids = 1'b0;
        endcase
    endfunction

    function automatic logic has_valc(input logic [3:0] ic);
        case (ic)
            4'h3, 4'h4, 4'h5, 4'h7, 4'h8: has_valc = 1'b1;
            default:                      has_valc = 1'b0;
        endcase
    endfunction

    // Byte 0 decodes straight from the bus so single-byte instructions finish on their only ack
    always_comb begin
        cur_icode_d = (cnt_q == 4'd0) ? imem_rdata[7:4] : icode_q;
        len_d       = instr_len(cur_icode_d);
        valc_idx_d  = 3'(cnt_q - (has_regids(cur_icode_d) ? 4'd2 : 4'd1));
        last_d      = (cnt_q == len_d - 4'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            cnt_q       <= '0;
            imem_req_q  <= 1'b0;
            imem_addr_q <= '0;
            out_valid_q <= 1'b0;
            icode_q     <= '0;
            ifun_q      <= '0;
            ra_q        <= 4'hF;
            rb_q        <= 4'hF;
            valc_q      <= '0;
            valp_q      <= '0;
            invalid_q   <= 1'b0;
            mem_error_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pc_valid) begin
                        pc_q        <= pc;
                        cnt_q       <= '0;
                        imem_req_q  <= 1'b1;
                        imem_addr_q <= pc;
                        icode_q     <= '0;
                        ifun_q      <= '0;
                        ra_q        <= 4'hF;
                        rb_q        <= 4'hF;
                        valc_q      <= '0;
                        invalid_q   <= 1'b0;
                        mem_error_q <= 1'b0;
                        state_q     <= FETCH;
                    end
                end
                FETCH: begin
                    if (imem_ack) begin
                        if (imem_error) begin
                            imem_req_q  <= 1'b0;
                            mem_error_q <= 1'b1;
                            icode_q     <= '0;
                            ifun_q      <= '0;
                            ra_q        <= 4'hF;
                            rb_q        <= 4'hF;
                            valc_q      <= '0;
                            valp_q      <= pc_q;
                            invalid_q   <= 1'b0;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            if (cnt_q == 4'd0) begin
                                icode_q   <= imem_rdata[7:4];
                                ifun_q    <= imem_rdata[3:0];
                                invalid_q <= (imem_rdata[7:4] > 4'hB);
                            end else if (cnt_q == 4'd1 && has_regids(icode_q)) begin
                                ra_q <= imem_rdata[7:4];
                                rb_q <= imem_rdata[3:0];
                            end else if (has_valc(icode_q)) begin
                                valc_q[{valc_idx_d, 3'b000} +: 8] <= imem_rdata;
                            end
                            if (last_d) begin
                                imem_req_q  <= 1'b0;
                                valp_q      <= pc_q + {60'd0, len_d};
                                out_valid_q <= 1'b1;
                                state_q     <= DONE;
                            end else begin
                                cnt_q       <= cnt_q + 4'd1;
                                imem_addr_q <= imem_addr_q + 64'd1;
                            end
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pc_ready      = (state_q == IDLE);
    assign imem_req      = imem_req_q;
    assign imem_addr     = imem_addr_q;
    assign out_valid     = out_valid_q;
    assign icode         = icode_q;
    assign ifun          = ifun_q;
    assign rA            = ra_q;
    assign rB            = rb_q;
    assign valC          = valc_q;
    assign valP          = valp_q;
    assign instr_invalid = invalid_q;
    assign mem_error     = mem_error_q;

endmodule
